avalon_sdram_responder: RTL and testbench

- Avalon-MM slave memory responder: the SDRAM-side end of the word-copy engine's master port.
- Serves word-addressed reads and writes from on-chip storage, with pipelined read latency, waitrequest back-pressure and readdatavalid returns.
- Used as the synthesizable SDRAM stand-in for copy-engine bring-up and as the bench target for any master in the design.

---
 rtl/avalon_sdram_responder.sv | 128 ++++++++++++
 tb/tb_avalon_sdram_responder.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_sdram_responder.sv
// avalon_sdram_responder: Avalon-MM word memory, pipelined in-order reads.
// Define WAIT_INJECT_EN to add LFSR-driven pseudo-random waitrequest stalls.
module avalon_sdram_responder #(
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 3,
  parameter int          MAX_PENDING  = 2,
  parameter logic [31:0] OOR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  output logic [15:0] err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int L  = READ_LATENCY;

  logic [31:0]   r_mem [DEPTH];
  logic [L-1:0]  r_vpipe;
  logic [31:0]   r_dpipe [L];
  logic [3:0]    r_pending;
  logic [15:0]   r_err;

  logic          w_in_range;
  logic          w_full;
  logic          w_inject;
  logic          w_stall;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic [1:0]    w_err_inc;
  logic [16:0]   w_err_sum;
  logic [L-1:0]  w_vin;
  logic [31:0]   w_din [L];

  assign w_in_range = (slave_address < 32'(DEPTH));
  assign w_idx      = slave_address[AW-1:0];
  assign w_rdata    = w_in_range ? r_mem[w_idx] : OOR_DATA;

`ifdef WAIT_INJECT_EN
  logic [15:0] r_lfsr;

  // Galois LFSR (taps 16,14,13,11) stepping every cycle for stall injection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_inject = (r_lfsr[1:0] == 2'b00);
`else
  assign w_inject = 1'b0;
`endif

  // A slot freed by this cycle's return can be reused by this cycle's read.
  assign w_full  = (r_pending == 4'(MAX_PENDING)) && !slave_readdatavalid;
  assign w_stall = !rst_n || (w_full && slave_read) || w_inject;

  assign slave_waitrequest = w_stall;
  assign w_wr_acc = slave_write && !w_stall;
  assign w_rd_acc = slave_read && !w_stall && !slave_write;

  assign w_err_inc = 2'(w_wr_acc && !w_in_range)
                   + 2'(w_wr_acc && slave_read)
                   + 2'(w_rd_acc && !w_in_range);
  assign w_err_sum = {1'b0, r_err} + 17'(w_err_inc);

  // Byte-masked write into storage; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_byteenable[b])
          r_mem[w_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
      end
    end
  end

  // Inputs of each latency stage: accept feeds stage 0, stages chain
  always_comb begin
    w_vin = '0;
    for (int i = 0; i < L; i++) w_din[i] = '0;
    w_vin[0] = w_rd_acc;
    w_din[0] = w_rdata;
    for (int i = 1; i < L; i++) begin
      w_vin[i] = r_vpipe[i-1];
      w_din[i] = r_dpipe[i-1];
    end
  end

  // Latency shift pipeline; data stages only load with a valid so they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpipe <= '0;
      for (int i = 0; i < L; i++) r_dpipe[i] <= '0;
    end else begin
      r_vpipe <= w_vin;
      for (int i = 0; i < L; i++) begin
        if (w_vin[i]) r_dpipe[i] <= w_din[i];
      end
    end
  end

  assign slave_readdatavalid = r_vpipe[L-1];
  assign slave_readdata      = r_dpipe[L-1];

  // Reads in flight: +1 on accept, -1 on return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else if (w_rd_acc && !slave_readdatavalid) r_pending <= r_pending + 4'd1;
    else if (!w_rd_acc && slave_readdatavalid) r_pending <= r_pending - 4'd1;
  end

  // Saturating protocol/range error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= '0;
    else r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  assign err_count = r_err;

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// tb_avalon_sdram_responder: randomized bench with a queue-based memory model.
// Build with WAIT_INJECT_EN defined to also cover stall injection.
module tb_avalon_sdram_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 3;
  localparam int          MAXP  = 2;
  localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [31:0] slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [3:0]  slave_byteenable = '0;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  avalon_sdram_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(MAXP), .OOR_DATA(OOR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest),
    .slave_address(slave_address),
    .slave_read(slave_read),
    .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid),
    .slave_write(slave_write),
    .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable),
    .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [31:0] mem_m [DEPTH];
  int          q_due [$];
  logic [31:0] q_dat [$];
  int          err_m = 0;
  logic [31:0] last_rd = '0;
  logic [15:0] lfsr_m = 16'hACE1;

  // expected outputs for the current cycle
  logic        ew, ev;
  logic [31:0] ed;
  int          ee;

  // observed outputs for the current cycle
  logic        obs_v;
  logic [31:0] obs_d;
  int          obs_cyc;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_eval();
    int inc;
    if (!rst_n) begin
      ew = 1'b1; ev = 1'b0; ed = '0; ee = 0;
      q_due.delete(); q_dat.delete();
      err_m = 0; last_rd = '0; lfsr_m = 16'hACE1;
      return;
    end
    ev = (q_due.size() > 0) && (q_due[0] == cyc);
    ed = ev ? q_dat[0] : last_rd;
    ee = err_m;
    ew = (q_due.size() == MAXP) && slave_read && !ev;
`ifdef WAIT_INJECT_EN
    if (lfsr_m[1:0] == 2'b00) ew = 1'b1;
    lfsr_m = lfsr_next(lfsr_m);
`endif
    if (ev) begin
      void'(q_due.pop_front());
      void'(q_dat.pop_front());
      last_rd = ed;
    end
    if (!ew) begin
      inc = 0;
      if (slave_write) begin
        if (slave_address < 32'(DEPTH)) begin
          for (int b = 0; b < 4; b++)
            if (slave_byteenable[b])
              mem_m[slave_address[9:0]][8*b +: 8] = slave_writedata[8*b +: 8];
        end else inc++;
        if (slave_read) inc++;
      end else if (slave_read) begin
        q_due.push_back(cyc + LAT);
        if (slave_address < 32'(DEPTH)) q_dat.push_back(mem_m[slave_address[9:0]]);
        else begin
          q_dat.push_back(OOR);
          inc++;
        end
      end
      err_m = (err_m + inc > 65535) ? 65535 : err_m + inc;
    end
  endtask

  // one bus cycle: drive after the edge, compare outputs mid-cycle
  task automatic bus_cycle(input logic rs, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output bit acc);
    @(posedge clk);
    #1;
    rst_n = rs;
    slave_read = rd;
    slave_write = wr;
    slave_address = a;
    slave_writedata = wd;
    slave_byteenable = be;
    @(negedge clk);
    model_eval();
    checks++;
    if (slave_waitrequest !== ew) begin
      errors++;
      $display("FAIL waitrequest cyc %0d got %b exp %b", cyc, slave_waitrequest, ew);
    end
    checks++;
    if (slave_readdatavalid !== ev) begin
      errors++;
      $display("FAIL readdatavalid cyc %0d got %b exp %b", cyc, slave_readdatavalid, ev);
    end
    checks++;
    if (slave_readdata !== ed) begin
      errors++;
      $display("FAIL readdata cyc %0d got %h exp %h", cyc, slave_readdata, ed);
    end
    checks++;
    if (err_count !== 16'(ee)) begin
      errors++;
      $display("FAIL err_count cyc %0d got %0d exp %0d", cyc, err_count, ee);
    end
    acc = rs && !ew && (rd || wr);
    obs_v = slave_readdatavalid;
    obs_d = slave_readdata;
    obs_cyc = cyc;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    bit acc;
    int n = 0;
    do begin
      bus_cycle(1'b1, 1'b0, 1'b1, a, wd, be, acc);
      n++;
    end while (!acc && n < 50);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL write_timeout addr %0d got stalled exp accepted", a);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output int t_acc);
    bit acc;
    int n = 0;
    do begin
      bus_cycle(1'b1, 1'b1, 1'b0, a, '0, '0, acc);
      n++;
    end while (!acc && n < 50);
    t_acc = obs_cyc;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL read_timeout addr %0d got stalled exp accepted", a);
    end
  endtask

  task automatic wait_return(output logic [31:0] d, output int t);
    bit acc;
    int n = 0;
    d = '0;
    t = -1;
    while (t < 0 && n < 20) begin
      bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
      n++;
      if (obs_v) begin
        d = obs_d;
        t = obs_cyc;
      end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL return_timeout got none exp readdatavalid");
    end
  endtask

  task automatic test_reset();
    bit acc;
    bus_cycle(1'b0, 1'b1, 1'b1, 32'd3, 32'h1, 4'hF, acc);
    checks++;
    if (slave_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait got %b exp 1", slave_waitrequest);
    end
    checks++;
    if (err_count !== 16'd0 || slave_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got err %0d rd %h exp 0 0", err_count, slave_readdata);
    end
    bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
    for (int i = 0; i < DEPTH; i++) do_write(32'(i), $urandom, 4'hF);
  endtask

  task automatic test_basic();
    int t0, t;
    logic [31:0] d;
    do_write(32'd5, 32'h1234_5678, 4'hF);
    do_read(32'd5, t0);
    wait_return(d, t);
    checks++;
    if (t - t0 !== LAT) begin
      errors++;
      $display("FAIL basic_latency got %0d exp %0d", t - t0, LAT);
    end
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL basic_data got %h exp 12345678", d);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_err got %0d exp 0", err_count);
    end
  endtask

  task automatic test_byteenable();
    int t0, t;
    logic [31:0] d;
    do_write(32'd7, 32'hFFFF_FFFF, 4'hF);
    do_write(32'd7, 32'h0000_00AA, 4'b0001);
    do_write(32'd7, 32'h1111_1111, 4'b0000);
    do_read(32'd7, t0);
    wait_return(d, t);
    checks++;
    if (d !== 32'hFFFF_FFAA) begin
      errors++;
      $display("FAIL byteenable_data got %h exp ffffffaa", d);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int k = 0, stall = 0, outst = 0, maxo = 0;
    logic [31:0] got [$];
    for (int c = 0; c < 40 && (k < 3 || got.size() < 3); c++) begin
      bus_cycle(1'b1, k < 3, 1'b0, 32'(k), '0, '0, acc);
      if (obs_v) begin
        got.push_back(obs_d);
        outst--;
      end
      if (acc) begin
        k++;
        outst++;
      end else if (k == 2) stall++;
      if (outst > maxo) maxo = outst;
    end
`ifndef WAIT_INJECT_EN
    checks++;
    if (stall !== 1) begin
      errors++;
      $display("FAIL b2b_stall got %0d exp 1", stall);
    end
`endif
    checks++;
    if (maxo > MAXP) begin
      errors++;
      $display("FAIL b2b_pending got %0d exp <= %0d", maxo, MAXP);
    end
    checks++;
    if (got.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++;
      if (got[i] !== mem_m[i]) begin
        errors++;
        $display("FAIL b2b_order idx %0d got %h exp %h", i, got[i], mem_m[i]);
      end
    end
  endtask

  task automatic test_oor();
    int t0, t;
    logic [31:0] d;
    logic [31:0] m0;
    bit acc;
    m0 = mem_m[0];
    do_read(32'd2000, t0);
    wait_return(d, t);
    checks++;
    if (d !== OOR || t - t0 !== LAT) begin
      errors++;
      $display("FAIL oor_read got %h lat %0d exp %h lat %0d", d, t - t0, OOR, LAT);
    end
    do_write(32'd1024, 32'h5555_5555, 4'hF);
    do_read(32'd0, t0);
    wait_return(d, t);
    checks++;
    if (d !== m0) begin
      errors++;
      $display("FAIL oor_write_alias got %h exp %h", d, m0);
    end
    bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL oor_err got %0d exp 2", err_count);
    end
  endtask

  task automatic test_reset_midflight();
    int t0, t, seen = 0;
    logic [31:0] d;
    bit acc;
    do_read(32'd9, t0);
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
      checks++;
      if (slave_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL midreset_wait got %b exp 1", slave_waitrequest);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
      if (obs_v) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_drop got %0d valids exp 0", seen);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_err got %0d exp 0", err_count);
    end
    do_read(32'd9, t0);
    wait_return(d, t);
    checks++;
    if (d !== mem_m[9]) begin
      errors++;
      $display("FAIL midreset_mem got %h exp %h", d, mem_m[9]);
    end
  endtask

  task automatic test_random();
    bit acc;
    int r;
    logic [31:0] a;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 4000))
                                       : 32'($urandom_range(0, 63));
      bus_cycle(1'b1, r <= 3 || r == 7, (r >= 4 && r <= 7), a, $urandom,
                4'($urandom_range(0, 15)), acc);
    end
    for (int i = 0; i < 10; i++) bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
    checks++;
    if (err_count !== 16'(err_m) || q_due.size() != 0) begin
      errors++;
      $display("FAIL random_final got err %0d exp %0d (%0d left)", err_count, err_m, q_due.size());
    end
  endtask

  task automatic test_sequential();
    logic [31:0] data [100];
    logic [31:0] got [$];
    bit acc;
    int k = 0;
    for (int i = 0; i < 100; i++) begin
      data[i] = $urandom;
      do_write(32'(i), data[i], 4'hF);
    end
    for (int c = 0; c < 1000 && got.size() < 100; c++) begin
      bus_cycle(1'b1, k < 100, 1'b0, 32'(k), '0, '0, acc);
      if (obs_v) got.push_back(obs_d);
      if (acc) k++;
    end
    checks++;
    if (got.size() !== 100) begin
      errors++;
      $display("FAIL seq_count got %0d exp 100", got.size());
    end
    for (int i = 0; i < got.size() && i < 100; i++) begin
      checks++;
      if (got[i] !== data[i]) begin
        errors++;
        $display("FAIL seq_data idx %0d got %h exp %h", i, got[i], data[i]);
      end
    end
  endtask

`ifdef WAIT_INJECT_EN
  task automatic test_inject_repeat();
    bit acc;
    logic [39:0] p0, p1;
    for (int run = 0; run < 2; run++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
      for (int i = 0; i < 40; i++) begin
        bus_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        if (run == 0) p0[i] = slave_waitrequest;
        else p1[i] = slave_waitrequest;
      end
    end
    checks++;
    if (p0 !== p1) begin
      errors++;
      $display("FAIL inject_repeat got %h exp %h", p1, p0);
    end
    checks++;
    if (p0 == '0) begin
      errors++;
      $display("FAIL inject_active got no stalls exp some");
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_byteenable();
    test_back_to_back();
    test_oor();
    test_reset_midflight();
    test_random();
    test_sequential();
`ifdef WAIT_INJECT_EN
    test_inject_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
